// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell stepped LSB first under a small
// IDLE/RUN/DONE controller, with registered result and carry-out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH:0]   ss_cat;
    logic [WIDTH-1:0] ss_next;
    logic             last;

    full_adder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Concatenate then drop the LSB so the shift is legal even at WIDTH=1.
    assign ss_cat  = {fa_sum, ss};
    assign ss_next = ss_cat[WIDTH:1];
    assign last    = (cnt == CW'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            ss     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= op_a;
                        sb    <= op_b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    ss    <= ss_next;
                    carry <= fa_cout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        result <= ss_next;
                        cout   <= fa_cout;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised self-checking bench for serial_adder_ctrl, comparing against
// plain integer addition at WIDTH=8 and exhaustively at WIDTH=1.
module tb_serial_adder_ctrl;
    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       c1;
    logic       busy1;
    logic       done1;
    logic [0:0] res1;
    logic       cout1;

    int checks;
    int failures;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start1),
        .op_a   (a1),
        .op_b   (b1),
        .cin    (c1),
        .busy   (busy1),
        .done   (done1),
        .result (res1),
        .cout   (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
        int s;
        s = int'(a) + int'(b) + int'(c);
        return 9'(s % 512);
    endfunction

    // Issue one addition and watch it complete; k counts cycles after the accept edge.
    task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output int nbusy, output int done_at,
                          output logic [8:0] got, output bit bad);
        logic [8:0] prev;
        @(negedge clk);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prev = {cout, result};
        nbusy = 0; done_at = -1; got = 'x; bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (busy && done) bad = 1'b1;
            if (busy) begin
                nbusy++;
                if ({cout, result} !== prev) bad = 1'b1;
            end
            if (done) begin
                done_at = k;
                got = {cout, result};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        op_a = 8'hA5; op_b = 8'h5A; cin = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int nb, da; logic [8:0] got; bit bad;
        do_add(8'h5A, 8'h33, 1'b0, nb, da, got, bad);
        checks++; if (nb !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", nb); end
        checks++; if (da !== 9) begin failures++; $display("FAIL basic_done_latency got=%0d exp=9", da); end
        checks++; if (got !== 9'h08D) begin failures++; $display("FAIL basic_sum got=%h exp=08d", got); end
        checks++; if (bad) begin failures++; $display("FAIL basic_run_integrity got=1 exp=0"); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_carry();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       tc [3];
        int nb, da; logic [8:0] got, exp; bit bad;
        logic [7:0] a, b; logic c;
        ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0;
        ta[1] = 8'hFF; tb[1] = 8'hFF; tc[1] = 1'b1;
        ta[2] = 8'h00; tb[2] = 8'h00; tc[2] = 1'b1;
        for (int i = 0; i < 23; i++) begin
            if (i < 3) begin
                a = ta[i]; b = tb[i]; c = tc[i];
            end else begin
                a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            end
            exp = model(a, b, c);
            do_add(a, b, c, nb, da, got, bad);
            checks++; if (got !== exp) begin failures++; $display("FAIL add_%0d %h+%h+%b got=%h exp=%h", i, a, b, c, got, exp); end
            checks++; if (da !== 9 || nb !== 8 || bad) begin failures++; $display("FAIL timing_%0d done_at=%0d busy=%0d bad=%b exp=9/8/0", i, da, nb, bad); end
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] a, b; logic [8:0] exp, got; int da, extra;
        a = 8'($urandom); b = 8'($urandom);
        exp = model(a, b, 1'b1);
        @(negedge clk);
        op_a = a; op_b = b; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        da = -1; got = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 3) begin
                op_a = ~a; op_b = 8'h77; cin = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin da = k; got = {cout, result}; break; end
        end
        checks++; if (da !== 9) begin failures++; $display("FAIL ign_done_latency got=%0d exp=9", da); end
        checks++; if (got !== exp) begin failures++; $display("FAIL ign_sum got=%h exp=%h", got, exp); end
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL ign_no_second_op got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a0, b0, a1v, b1v;
        logic [8:0] e0, e1, g0, g1;
        int d0, d1;
        bit seen_busy2;
        a0 = 8'($urandom); b0 = 8'($urandom);
        a1v = 8'h3C; b1v = 8'h4E;
        e0 = model(a0, b0, 1'b0);
        e1 = model(a1v, b1v, 1'b1);
        @(negedge clk);
        op_a = a0; op_b = b0; cin = 1'b0; start = 1'b1;
        d0 = -1; d1 = -1; g0 = 'x; g1 = 'x; seen_busy2 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin op_a = a1v; op_b = b1v; cin = 1'b1; end
            if (done && d0 < 0) begin
                d0 = k; g0 = {cout, result};
            end else if (done && d0 >= 0) begin
                d1 = k; g1 = {cout, result}; break;
            end
            if (d0 >= 0 && busy && !seen_busy2) begin
                seen_busy2 = 1'b1; start = 1'b0;
            end
        end
        start = 1'b0;
        checks++; if (g0 !== e0) begin failures++; $display("FAIL b2b_first_sum got=%h exp=%h", g0, e0); end
        checks++; if (g1 !== e1) begin failures++; $display("FAIL b2b_second_sum got=%h exp=%h", g1, e1); end
        checks++; if (d0 !== 9) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=9", d0); end
        checks++; if (d1 - d0 !== 10) begin failures++; $display("FAIL b2b_issue_interval got=%0d exp=10", d1 - d0); end
    endtask

    task automatic test_reset_mid();
        int stray;
        @(negedge clk);
        op_a = 8'h81; op_b = 8'h42; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_run4 got=%b exp=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_flags busy=%b done=%b exp=0/0", busy, done); end
        checks++; if ({cout, result} !== 9'h000) begin failures++; $display("FAIL mid_outputs got=%h exp=000", {cout, result}); end
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", stray); end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_blocks_start got=%b exp=0", busy); end
    endtask

    task automatic test_width1();
        int da, nb;
        logic [1:0] got, exp;
        for (int i = 0; i < 8; i++) begin
            exp = 2'((i >> 2) & 1) + 2'((i >> 1) & 1) + 2'(i & 1);
            @(negedge clk);
            a1 = 1'((i >> 2) & 1); b1 = 1'((i >> 1) & 1); c1 = 1'(i & 1); start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            da = -1; nb = 0; got = 'x;
            for (int k = 1; k <= 10; k++) begin
                if (k > 1) @(negedge clk);
                if (busy1) nb++;
                if (done1) begin da = k; got = {cout1, res1}; break; end
            end
            checks++; if (got !== exp) begin failures++; $display("FAIL w1_sum_%0d got=%b exp=%b", i, got, exp); end
            checks++; if (da !== 2 || nb !== 1) begin failures++; $display("FAIL w1_timing_%0d done_at=%0d busy=%0d exp=2/1", i, da, nb); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_carry();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
